rv32i_fetch: RTL and testbench
==============================

RV32I_FETCH -- requirements
Module: rv32i_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), SHALL be the reset/flush value of instr.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 imem_req_valid  output  1  SHALL flag a valid instruction-memory read request.
REQ-006 imem_req_addr  output  32  SHALL carry the word-aligned request address.
REQ-007 imem_req_ready  input  1  SHALL mean memory accepts the request this cycle.
REQ-008 imem_resp_valid  input  1  SHALL mean imem_resp_data is valid this cycle.
REQ-009 imem_resp_data  input  32  SHALL be the returned instruction word.
REQ-010 redirect_valid  input  1  SHALL request a PC change (branch/jump), single-cycle pulse.
REQ-011 redirect_pc  input  32  SHALL be the redirect target.
REQ-012 instr_valid  output  1  SHALL flag instr/pc_out valid for the downstream decoder.
REQ-013 instr  output  32  SHALL be the fetched instruction word, fed to the decoder's instr input.
REQ-014 pc_out  output  32  SHALL be the address instr was fetched from.
REQ-015 instr_ready  input  1  SHALL mean downstream consumes instr this cycle.

Function
REQ-016 The block SHALL use FSM states IDLE, REQ, WAIT, HOLD, DRAIN, with a 32-bit pc register.
REQ-017 imem_req_valid SHALL be 1 only in REQ; imem_req_addr SHALL equal pc at all times.
REQ-018 pc[1:0] SHALL always be 2'b00; redirect_pc[1:0] SHALL be forced to zero when loaded.
REQ-019 IDLE -> REQ unconditionally after one cycle.
REQ-020 REQ, handshake (imem_req_valid & imem_req_ready), no redirect: latch fetch_pc <= pc, pc <= pc + 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go WAIT.
REQ-021 WAIT, imem_resp_valid, no redirect: instr <= imem_resp_data, pc_out <= fetch_pc, instr_valid <= 1, go HOLD.
REQ-022 HOLD: instr, pc_out, instr_valid SHALL stay stable until instr_ready; on instr_ready & ~redirect_valid, instr_valid <= 0, go REQ.
REQ-023 Fetch-to-issue latency SHALL be: request accepted at cycle N, response at N+k (k >= 1), instr_valid at N+k+1; at most one request SHALL be outstanding.
REQ-024 redirect_valid SHALL have priority over every other event in every state: pc <= {redirect_pc[31:2],2'b00}, instr_valid <= 0, instr <= NOP_INSTR.
REQ-025 Redirect next state: REQ from IDLE, REQ, HOLD; DRAIN from WAIT without imem_resp_valid; REQ from WAIT with imem_resp_valid same cycle (response discarded); DRAIN from REQ if the handshake completes the same cycle (accepted request is stale).
REQ-026 DRAIN SHALL discard the next imem_resp_valid beat and then go REQ; a further redirect in DRAIN SHALL update pc only and stay in DRAIN unless the response arrives the same cycle, in which case go REQ.
REQ-027 imem_resp_valid outside WAIT/DRAIN SHALL be ignored.
REQ-028 A redirect in HOLD coinciding with instr_ready SHALL count as consumed; the held instruction SHALL not reappear.

Reset
REQ-029 While rst=1 at a clock edge: state <= IDLE, pc <= RESET_PC, instr_valid <= 0, instr <= NOP_INSTR, pc_out <= 0, fetch_pc <= 0; consequently imem_req_valid = 0.
REQ-030 rst SHALL override any in-flight transaction; a response arriving after reset deassertion for a pre-reset request SHALL be ignored (state is not WAIT/DRAIN).
REQ-031 First request SHALL appear in the second cycle after rst deasserts, with address RESET_PC.

Verification
REQ-032 Reset release, imem_req_ready=1, 1-cycle memory returning 32'h0050_0093, instr_ready=1 -> first req addr 0x0, instr=32'h0050_0093, pc_out=0x0, next req addr 0x4.
REQ-033 Downstream stall: instr_ready=0 for 5 cycles in HOLD -> instr/pc_out unchanged, instr_valid=1, no new request; instr_ready=1 -> request to pc_out+4 next cycle.
REQ-034 Redirect in WAIT to 32'h0000_0103, response 3 cycles later -> response dropped, instr_valid never 1 for it, next req addr 0x100.
REQ-035 Redirect same cycle as request handshake at pc 0x8 to 0x40 -> DRAIN, stale response dropped, next req addr 0x40.
REQ-036 pc at 32'hFFFF_FFFC, handshake -> next req addr 0x0000_0000, pc_out of that fetch = 32'hFFFF_FFFC.
REQ-037 rst asserted in WAIT, response arrives 1 cycle after release -> ignored, first output instr comes from RESET_PC fetch.

Source files
------------

// File: rtl/rv32i_fetch_if.sv
// rv32i_fetch_if -- groups the fetch unit's instruction-memory, redirect and
// decoder-side signals.
//   master : the fetch unit (drives memory requests and the decoder outputs)
//   slave  : the environment (instruction memory, branch unit, decoder)
interface rv32i_fetch_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        instr_ready;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, pc_out,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, pc_out,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/rv32i_fetch.sv
// rv32i_fetch -- single-outstanding RV32I instruction fetch unit.
// Issues one word-aligned read at a time, holds the returned word for the
// decoder until consumed, and handles branch/jump redirects at any point
// (discarding in-flight responses that belong to the old instruction stream).
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : rv32i_fetch_if.master (imem request/response, redirect, decoder side)
module rv32i_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  rv32i_fetch_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] fetch_pc;
  logic        instr_valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;

  logic        handshake;
  logic [31:0] redirect_target;

  assign handshake       = (state == REQ) && bus.imem_req_ready;
  assign redirect_target = {bus.redirect_pc[31:2], 2'b00};

  assign bus.imem_req_valid = (state == REQ);
  assign bus.imem_req_addr  = pc;
  assign bus.instr_valid    = instr_valid_q;
  assign bus.instr          = instr_q;
  assign bus.pc_out         = pc_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= {RESET_PC[31:2], 2'b00};
      fetch_pc      <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      pc_out_q      <= '0;
    end else if (bus.redirect_valid) begin
      // Redirect wins over everything. If a request is still in flight
      // (accepted this cycle, or waiting without a response yet) its
      // response belongs to the old stream and must be drained first.
      pc            <= redirect_target;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      unique case (state)
        IDLE, HOLD: state <= REQ;
        REQ:        state <= handshake ? DRAIN : REQ;
        WAIT:       state <= bus.imem_resp_valid ? REQ : DRAIN;
        DRAIN:      state <= bus.imem_resp_valid ? REQ : DRAIN;
        default:    state <= IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (bus.imem_req_ready) begin
            fetch_pc <= pc;
            pc       <= pc + 32'd4;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_resp_valid) begin
            instr_q       <= bus.imem_resp_data;
            pc_out_q      <= fetch_pc;
            instr_valid_q <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            state         <= REQ;
          end
        end
        DRAIN: begin
          if (bus.imem_resp_valid) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_fetch.sv
module tb_rv32i_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] J   = 32'hDEAD_BEEF;
  localparam logic [31:0] D1  = 32'h0050_0093;
  localparam logic [31:0] D2  = 32'h00A0_0113;
  localparam logic [31:0] D3  = 32'h0030_0193;
  localparam logic [31:0] D4  = 32'h0040_0213;
  localparam logic [31:0] D5  = 32'h0070_0293;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  rv32i_fetch_if fif ();

  rv32i_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (fif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rdy, rv;
    logic [31:0] rd;
    logic        redir;
    logic [31:0] rpc;
    logic        ir;
    logic        e_rqv;
    logic [31:0] e_rqa;
    logic        e_iv;
    logic [31:0] e_ins, e_pco;
  } vec_t;

  vec_t tbl[25];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic redir, input logic [31:0] rpc, input logic ir);
    rst                 = r;
    fif.imem_req_ready  = rdy;
    fif.imem_resp_valid = rv;
    fif.imem_resp_data  = rd;
    fif.redirect_valid  = redir;
    fif.redirect_pc     = rpc;
    fif.instr_ready     = ir;
  endtask

  task automatic cyc(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                     input logic redir, input logic [31:0] rpc, input logic ir);
    drive(r, rdy, rv, rd, redir, rpc, ir);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit          pending, delivered, hs, last_resp, last_redir, prev_iv;
    int          cnt, idle;
    logic [31:0] paddr, exp_pc;
    logic        rv, rdy, ir, redir;
    logic [31:0] rd, rpc;

    //        rst rdy rv rd  rdr rpc          ir  rqv rqa          iv ins  pco
    tbl[0]  = '{1, 0, 0, 0,  0, 0,            0,  0, 32'h0,        0, NOP, 32'h0};
    tbl[1]  = '{1, 1, 1, J,  0, 0,            1,  0, 32'h0,        0, NOP, 32'h0};
    tbl[2]  = '{0, 1, 0, 0,  0, 0,            1,  1, 32'h0,        0, NOP, 32'h0};
    tbl[3]  = '{0, 1, 0, 0,  0, 0,            1,  0, 32'h4,        0, NOP, 32'h0};
    tbl[4]  = '{0, 1, 1, D1, 0, 0,            1,  0, 32'h4,        1, D1,  32'h0};
    tbl[5]  = '{0, 1, 0, 0,  0, 0,            1,  1, 32'h4,        0, D1,  32'h0};
    tbl[6]  = '{0, 1, 0, 0,  0, 0,            0,  0, 32'h8,        0, D1,  32'h0};
    tbl[7]  = '{0, 1, 1, D2, 0, 0,            0,  0, 32'h8,        1, D2,  32'h4};
    tbl[8]  = '{0, 1, 0, 0,  0, 0,            0,  0, 32'h8,        1, D2,  32'h4};
    tbl[9]  = '{0, 1, 0, 0,  0, 0,            0,  0, 32'h8,        1, D2,  32'h4};
    tbl[10] = '{0, 1, 1, J,  0, 0,            0,  0, 32'h8,        1, D2,  32'h4};
    tbl[11] = '{0, 1, 0, 0,  0, 0,            0,  0, 32'h8,        1, D2,  32'h4};
    tbl[12] = '{0, 1, 0, 0,  0, 0,            0,  0, 32'h8,        1, D2,  32'h4};
    tbl[13] = '{0, 1, 0, 0,  0, 0,            1,  1, 32'h8,        0, D2,  32'h4};
    tbl[14] = '{0, 1, 0, 0,  1, 32'h40,       0,  0, 32'h40,       0, NOP, 32'h4};
    tbl[15] = '{0, 0, 1, J,  0, 0,            0,  1, 32'h40,       0, NOP, 32'h4};
    tbl[16] = '{0, 1, 0, 0,  0, 0,            0,  0, 32'h44,       0, NOP, 32'h4};
    tbl[17] = '{0, 0, 0, 0,  1, 32'h103,      0,  0, 32'h100,      0, NOP, 32'h4};
    tbl[18] = '{0, 0, 0, 0,  0, 0,            0,  0, 32'h100,      0, NOP, 32'h4};
    tbl[19] = '{0, 0, 0, 0,  0, 0,            0,  0, 32'h100,      0, NOP, 32'h4};
    tbl[20] = '{0, 0, 1, J,  0, 0,            0,  1, 32'h100,      0, NOP, 32'h4};
    tbl[21] = '{0, 1, 0, 0,  0, 0,            0,  0, 32'h104,      0, NOP, 32'h4};
    tbl[22] = '{0, 0, 1, D3, 0, 0,            0,  0, 32'h104,      1, D3,  32'h100};
    tbl[23] = '{0, 0, 0, 0,  1, 32'h200,      1,  1, 32'h200,      0, NOP, 32'h100};
    tbl[24] = '{0, 0, 0, 0,  0, 0,            0,  1, 32'h200,      0, NOP, 32'h100};

    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 25; i++) begin
      cyc(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].redir, tbl[i].rpc, tbl[i].ir);
      chk($sformatf("vec%0d.req_valid", i), 32'(fif.imem_req_valid), 32'(tbl[i].e_rqv));
      chk($sformatf("vec%0d.req_addr", i),  fif.imem_req_addr,       tbl[i].e_rqa);
      chk($sformatf("vec%0d.instr_valid", i), 32'(fif.instr_valid),  32'(tbl[i].e_iv));
      chk($sformatf("vec%0d.instr", i),     fif.instr,               tbl[i].e_ins);
      chk($sformatf("vec%0d.pc_out", i),    fif.pc_out,              tbl[i].e_pco);
    end

    // pc wrap: redirect to the top word (low bits must be masked), then fetch it
    cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0);
    chk("wrap.req_addr_top", fif.imem_req_addr, 32'hFFFF_FFFC);
    chk("wrap.req_valid", 32'(fif.imem_req_valid), 32'd1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("wrap.next_addr", fif.imem_req_addr, 32'h0);
    cyc(0, 0, 1, D4, 0, 0, 0);
    chk("wrap.instr", fif.instr, D4);
    chk("wrap.pc_out", fif.pc_out, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("wrap.req_after", fif.imem_req_addr, 32'h0);

    // reset while waiting; late response after release must be ignored
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rstwait.req_valid", 32'(fif.imem_req_valid), 32'd0);
    chk("rstwait.req_addr", fif.imem_req_addr, 32'h0);
    cyc(0, 0, 1, J, 0, 0, 0);
    chk("rstwait.iv_a", 32'(fif.instr_valid), 32'd0);
    chk("rstwait.req_first", 32'(fif.imem_req_valid), 32'd1);
    cyc(0, 0, 1, J, 0, 0, 0);
    chk("rstwait.iv_b", 32'(fif.instr_valid), 32'd0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, D5, 0, 0, 0);
    chk("rstwait.iv", 32'(fif.instr_valid), 32'd1);
    chk("rstwait.instr", fif.instr, D5);
    chk("rstwait.pc_out", fif.pc_out, 32'h0);

    // randomized run against a program-flow model: consumed instructions
    // must follow sequential addresses from the last redirect target, and
    // each word must be the memory contents at its pc_out
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    pending = 0; cnt = 0; paddr = '0; exp_pc = 32'h0; idle = 0;
    prev_iv = 0; last_resp = 0; last_redir = 0;
    for (int c = 0; c < 4000; c++) begin
      rv = 0; rd = $urandom;
      if (pending && cnt == 0) begin
        rv = 1; rd = memf(paddr);
      end else if (!pending && $urandom_range(7) == 0) begin
        rv = 1;
      end
      rdy   = ($urandom_range(2) != 0);
      ir    = 1'($urandom_range(1));
      redir = ($urandom_range(11) == 0);
      rpc   = $urandom;
      drive(0, rdy, rv, rd, redir, rpc, ir);

      delivered = pending && rv;
      if (delivered) pending = 0;
      else if (pending) cnt--;
      hs = fif.imem_req_valid && rdy;
      if (hs) begin
        chk("rand.one_outstanding", 32'(pending), 32'd0);
        chk("rand.addr_align", 32'(fif.imem_req_addr[1:0]), 32'd0);
        pending = 1; paddr = fif.imem_req_addr; cnt = $urandom_range(3);
      end
      if (fif.instr_valid && ir) begin
        chk("rand.pc_out", fif.pc_out, exp_pc);
        chk("rand.instr", fif.instr, memf(fif.pc_out));
        exp_pc = exp_pc + 32'd4;
        idle = 0;
      end
      if (redir) begin
        exp_pc = {rpc[31:2], 2'b00};
        idle = 0;
      end
      last_resp = delivered; last_redir = redir;

      @(posedge clk);
      #1;
      if (fif.instr_valid && !prev_iv)
        chk("rand.latency", 32'(last_resp && !last_redir), 32'd1);
      prev_iv = fif.instr_valid;
      idle++;
      if (idle > 200) begin
        chk("rand.liveness", 32'(idle), 32'd200);
        idle = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
